// File: rtl/serial_alu_pkg.sv
// Shared op codes, FSM/slice encodings and decode helpers for serial_alu.
// Optional SLTU support is enabled by defining SERIAL_ALU_SLTU_EN.
package alu_pkg;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_NOR  = 4'b1100;
    localparam logic [3:0] OP_SLTU = 4'b1000;

`ifdef SERIAL_ALU_SLTU_EN
    localparam logic SLTU_EN = 1'b1;
`else
    localparam logic SLTU_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        SL_AND = 2'd0,
        SL_OR  = 2'd1,
        SL_ADD = 2'd2
    } slice_op_e;

    // Ops that run as A + ~B + 1: both subtract-style compares share the SUB datapath.
    function automatic logic needs_sub(input logic [3:0] op);
        return (op == OP_SUB) || (op == OP_SLT) || (SLTU_EN && (op == OP_SLTU));
    endfunction

    function automatic logic op_known(input logic [3:0] op);
        logic known;
        case (op)
            OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_NOR: known = 1'b1;
            OP_SLTU: known = SLTU_EN;
            default: known = 1'b0;
        endcase
        return known;
    endfunction

endpackage

// File: rtl/serial_alu_if.sv
// Operand/result handshake bundle for serial_alu.
interface serial_alu_if #(
    parameter int WIDTH = 32
) ();
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             overflow;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, zero, overflow
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, zero, overflow
    );
endinterface

// File: rtl/serial_alu_digit_slice.sv
// Combinational DIGIT_W-wide ALU slice; the caller ripples carry between cycles.
module alu_digit_slice
    import alu_pkg::*;
#(
    parameter int DIGIT_W = 8
) (
    input  logic [DIGIT_W-1:0] ai_i,
    input  logic [DIGIT_W-1:0] bi_i,
    input  logic               a_invert_i,
    input  logic               b_invert_i,
    input  logic               carry_in_i,
    input  slice_op_e          operation_i,
    output logic [DIGIT_W-1:0] result_o,
    output logic               carry_out_o,
    output logic               msb_carry_in_o
);

    logic [DIGIT_W-1:0] a_s;
    logic [DIGIT_W-1:0] b_s;
    logic [DIGIT_W:0]   sum_s;

    // Operand conditioning, adder and result select.
    always_comb begin
        a_s   = a_invert_i ? ~ai_i : ai_i;
        b_s   = b_invert_i ? ~bi_i : bi_i;
        sum_s = {1'b0, a_s} + {1'b0, b_s} + {{DIGIT_W{1'b0}}, carry_in_i};
        carry_out_o = sum_s[DIGIT_W];
        // Carry entering the top bit recovered from its sum bit.
        msb_carry_in_o = sum_s[DIGIT_W-1] ^ a_s[DIGIT_W-1] ^ b_s[DIGIT_W-1];
        case (operation_i)
            SL_AND:  result_o = a_s & b_s;
            SL_OR:   result_o = a_s | b_s;
            SL_ADD:  result_o = sum_s[DIGIT_W-1:0];
            default: result_o = {DIGIT_W{1'b0}};
        endcase
    end

endmodule

// File: rtl/serial_alu.sv
// Digit-serial ALU: one DIGIT_W slice per cycle, LSB digit first, valid/ready on both sides.
// Define SERIAL_ALU_SLTU_EN to add the unsigned set-less-than op (code 1000).
module serial_alu
    import alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int DIGIT_W = 8
) (
    input  logic         clk,
    input  logic         rst,
    serial_alu_if.slave  bus
);

    localparam int NDIG  = WIDTH / DIGIT_W;
    localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CNT_W-1:0] LAST_DIG = CNT_W'(NDIG - 1);
    localparam logic [WIDTH-1:0] DIG_MASK = WIDTH'({DIGIT_W{1'b1}});

    state_e             state_q,     state_d;
    logic [WIDTH-1:0]   a_q,         a_d;
    logic [WIDTH-1:0]   b_q,         b_d;
    logic [3:0]         op_q,        op_d;
    logic [CNT_W-1:0]   cnt_q,       cnt_d;
    logic               carry_q,     carry_d;
    logic [WIDTH-1:0]   result_q,    result_d;
    logic               zero_q,      zero_d;
    logic               overflow_q,  overflow_d;
    logic               out_valid_q, out_valid_d;
    logic               in_ready_q,  in_ready_d;

    logic               sub_s;
    logic               nor_s;
    logic               slt_s;
    logic               sltu_s;
    logic               arith_s;
    logic               write_s;
    slice_op_e          slice_op_s;
    logic [31:0]        shamt_s;
    logic [DIGIT_W-1:0] ai_s;
    logic [DIGIT_W-1:0] bi_s;
    logic [DIGIT_W-1:0] dig_res_s;
    logic [DIGIT_W-1:0] wr_digit_s;
    logic               cout_s;
    logic               msb_cin_s;
    logic               ovf_raw_s;
    logic               set_s;
    logic               last_s;

    // Decode of the latched op into slice controls.
    always_comb begin
        sub_s   = needs_sub(op_q);
        nor_s   = (op_q == OP_NOR);
        slt_s   = (op_q == OP_SLT);
        sltu_s  = SLTU_EN && (op_q == OP_SLTU);
        arith_s = (op_q == OP_ADD) || (op_q == OP_SUB);
        // Compares only feed carry/set; unknown ops leave zeros behind.
        write_s = op_known(op_q) && !slt_s && !sltu_s;
        case (op_q)
            OP_AND, OP_NOR: slice_op_s = SL_AND;
            OP_OR:          slice_op_s = SL_OR;
            default:        slice_op_s = SL_ADD;
        endcase
    end

    // Select the current digit of each latched operand.
    always_comb begin
        shamt_s    = 32'(cnt_q) * 32'(DIGIT_W);
        ai_s       = DIGIT_W'(a_q >> shamt_s);
        bi_s       = DIGIT_W'(b_q >> shamt_s);
        last_s     = (cnt_q == LAST_DIG);
        wr_digit_s = write_s ? dig_res_s : {DIGIT_W{1'b0}};
        ovf_raw_s  = msb_cin_s ^ cout_s;
        set_s      = dig_res_s[DIGIT_W-1] ^ ovf_raw_s;
    end

    alu_digit_slice #(
        .DIGIT_W (DIGIT_W)
    ) u_slice (
        .ai_i           (ai_s),
        .bi_i           (bi_s),
        .a_invert_i     (nor_s),
        .b_invert_i     (sub_s || nor_s),
        .carry_in_i     (carry_q),
        .operation_i    (slice_op_s),
        .result_o       (dig_res_s),
        .carry_out_o    (cout_s),
        .msb_carry_in_o (msb_cin_s)
    );

    // FSM next-state and datapath updates.
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        cnt_d       = cnt_q;
        carry_d     = carry_q;
        result_d    = result_q;
        zero_d      = zero_q;
        overflow_d  = overflow_q;
        out_valid_d = out_valid_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    a_d        = bus.a;
                    b_d        = bus.b;
                    op_d       = bus.op;
                    cnt_d      = {CNT_W{1'b0}};
                    carry_d    = needs_sub(bus.op);
                    result_d   = {WIDTH{1'b0}};
                    zero_d     = 1'b0;
                    overflow_d = 1'b0;
                    state_d    = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                result_d = (result_q & ~(DIG_MASK << shamt_s))
                         | (WIDTH'(wr_digit_s) << shamt_s);
                carry_d  = cout_s;
                cnt_d    = cnt_q + CNT_W'(1);
                if (last_s) begin
                    overflow_d = arith_s ? ovf_raw_s : 1'b0;
                    if (slt_s) begin
                        result_d = {{(WIDTH-1){1'b0}}, set_s};
                    end else if (sltu_s) begin
                        result_d = {{(WIDTH-1){1'b0}}, ~cout_s};
                    end else begin
                        result_d = result_d;
                    end
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                // First DONE cycle resolves zero from the settled result.
                if (!out_valid_q) begin
                    zero_d      = (result_q == {WIDTH{1'b0}});
                    out_valid_d = 1'b1;
                end else if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
        in_ready_d = (state_d == ST_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            a_q         <= {WIDTH{1'b0}};
            b_q         <= {WIDTH{1'b0}};
            op_q        <= 4'b0000;
            cnt_q       <= {CNT_W{1'b0}};
            carry_q     <= 1'b0;
            result_q    <= {WIDTH{1'b0}};
            zero_q      <= 1'b0;
            overflow_q  <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            cnt_q       <= cnt_d;
            carry_q     <= carry_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            overflow_q  <= overflow_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.zero      = zero_q;
    assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_serial_alu.sv
// Directed plus randomized bench for serial_alu against an arithmetic reference model.
module tb_serial_alu;
    import alu_pkg::*;

    localparam int WIDTH   = 32;
    localparam int DIGIT_W = 8;
    localparam int NDIG    = WIDTH / DIGIT_W;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   passes = 0;
    int   fails  = 0;

    serial_alu_if #(.WIDTH(WIDTH)) bus ();

    serial_alu #(.WIDTH(WIDTH), .DIGIT_W(DIGIT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic v);
        r = 32'd0;
        v = 1'b0;
        case (op)
            OP_AND: r = a & b;
            OP_OR:  r = a | b;
            OP_NOR: r = ~(a | b);
            OP_ADD: begin
                r = a + b;
                v = (a[31] == b[31]) && (r[31] != a[31]);
            end
            OP_SUB: begin
                r = a - b;
                v = (a[31] != b[31]) && (r[31] != a[31]);
            end
            OP_SLT: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
`ifdef SERIAL_ALU_SLTU_EN
            OP_SLTU: r = (a < b) ? 32'd1 : 32'd0;
`endif
            default: r = 32'd0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int hold, input string tag);
        logic [31:0] er;
        logic        ev;
        int          w;
        int          lat;
        model(op, a, b, er, ev);
        w = 0;
        while (bus.in_ready !== 1'b1 && w < 20) begin
            @(posedge clk); #1; w++;
        end
        chk({tag, " in_ready"}, 64'(bus.in_ready), 64'd1);
        bus.in_valid = 1'b1;
        bus.op = op;
        bus.a = a;
        bus.b = b;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.a = $urandom;
        bus.b = $urandom;
        bus.op = 4'($urandom);
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        chk({tag, " latency"}, 64'(lat), 64'(NDIG + 1));
        chk({tag, " result"}, 64'(bus.result), 64'(er));
        chk({tag, " zero"}, 64'(bus.zero), 64'(er == 32'd0));
        chk({tag, " overflow"}, 64'(bus.overflow), 64'(ev));
        for (int i = 0; i < hold; i++) begin
            bus.in_valid = 1'b1;
            @(posedge clk); #1;
            chk({tag, " hold"}, {30'd0, bus.out_valid, bus.in_ready, bus.result},
                {30'd0, 1'b1, 1'b0, er});
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        chk({tag, " handshake"}, {62'd0, bus.out_valid, bus.in_ready}, 64'd1);
    endtask

    initial begin
        logic [3:0]  ops [8];
        logic [31:0] ra;
        logic [31:0] rb;
        int          seen;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.op = 4'd0;
        bus.a  = 32'd0;
        bus.b  = 32'd0;

        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("reset outputs", {28'd0, bus.out_valid, bus.in_ready, bus.zero, bus.overflow, bus.result}, 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("reset in_ready", 64'(bus.in_ready), 64'd1);

        run_op(OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 0, "add_ovf");
        run_op(OP_SUB, 32'd5, 32'd5, 0, "sub_zero");
        run_op(OP_SUB, 32'h8000_0000, 32'h0000_0001, 0, "sub_ovf");
        run_op(OP_SLT, 32'hFFFF_FFFF, 32'h0000_0001, 0, "slt_neg");
        run_op(OP_SLT, 32'h0000_0001, 32'hFFFF_FFFF, 0, "slt_pos");
        run_op(OP_NOR, 32'hF0F0_F0F0, 32'h0F0F_0000, 0, "nor");
        run_op(OP_AND, 32'hDEAD_BEEF, 32'h0FF0_F00F, 10, "backpressure");
        run_op(OP_OR, 32'h1234_0000, 32'h0000_5678, 0, "after_bp");
        run_op(OP_SLTU, 32'h0000_0001, 32'hFFFF_FFFF, 0, "sltu");
        run_op(4'b0011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "unlisted");

        // Abort an ADD with reset during its second RUN cycle.
        while (bus.in_ready !== 1'b1) begin
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b1;
        bus.op = OP_ADD;
        bus.a = 32'h1111_1111;
        bus.b = 32'h2222_2222;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("abort outputs", {28'd0, bus.out_valid, bus.in_ready, bus.zero, bus.overflow, bus.result}, 64'd0);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid === 1'b1) seen = 1;
        end
        chk("abort no result", 64'(seen), 64'd0);
        run_op(OP_ADD, 32'd3, 32'd4, 0, "add_after_rst");

        ops[0] = OP_AND;
        ops[1] = OP_OR;
        ops[2] = OP_ADD;
        ops[3] = OP_SUB;
        ops[4] = OP_SLT;
        ops[5] = OP_NOR;
        ops[6] = OP_SLTU;
        for (int n = 0; n < 40; n++) begin
            ops[7] = 4'($urandom);
            ra = ($urandom_range(0, 3) == 0) ? (32'h8000_0000 - 32'($urandom_range(0, 1))) : 32'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? ra : 32'($urandom);
            run_op(ops[$urandom_range(0, 7)], ra, rb, int'($urandom_range(0, 2)), "random");
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
